// File: rtl/handshake_arb_sender_if.sv
// Bus bundle for handshake_arb_sender: requester side plus the cross-domain
// 4-phase handshake. master = the sender, slave = requesters/handshake peer.
interface handshake_arb_sender_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            o_grant;
    logic                          o_hs_valid;
    logic [DATA_WIDTH-1:0]         o_hs_data;
    logic [SRC_W-1:0]              o_hs_src;
    logic                          i_hs_ack;
    logic                          o_busy;
    logic                          o_done;
    logic                          o_timeout;

    modport master (
        input  i_req, i_data, i_hs_ack,
        output o_grant, o_hs_valid, o_hs_data, o_hs_src, o_busy, o_done, o_timeout
    );

    modport slave (
        output i_req, i_data, i_hs_ack,
        input  o_grant, o_hs_valid, o_hs_data, o_hs_src, o_busy, o_done, o_timeout
    );
endinterface

// File: rtl/handshake_arb_sender.sv
// Round-robin arbiter that launches one payload at a time into a 4-phase handshake.
// Define HANDSHAKE_ARB_SENDER_TIMEOUT_EN to build the sticky transfer watchdog.
module handshake_arb_sender #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    handshake_arb_sender_if.master bus
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]            state_q, state_next;
    logic [SRC_W-1:0]      ptr_q, ptr_next;
    logic                  hs_valid_q, hs_valid_next;
    logic [DATA_WIDTH-1:0] hs_data_q, hs_data_next;
    logic [SRC_W-1:0]      hs_src_q, hs_src_next;
    logic                  done_q, done_next;
    logic [NUM_REQ-1:0]    grant_c;

    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic                  win_found;
    logic [SRC_W-1:0]      win_idx;
    logic [SRC_W-1:0]      cand;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_data[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = SRC_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next state and registered-output values.
    always_comb begin
        state_next   = state_q;
        ptr_next     = ptr_q;
        hs_data_next = hs_data_q;
        hs_src_next  = hs_src_q;
        done_next    = 1'b0;
        grant_c      = '0;

        case (state_q)
            IDLE: begin
                // A still-high ack belongs to an abandoned transfer; wait it out.
                if (win_found && !bus.i_hs_ack) begin
                    grant_c      = NUM_REQ'(1) << win_idx;
                    ptr_next     = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
                    hs_data_next = req_data[win_idx];
                    hs_src_next  = win_idx;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (bus.i_hs_ack) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.i_hs_ack) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        hs_valid_next = (state_next == SEND);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hs_valid_q <= 1'b0;
            hs_data_q  <= '0;
            hs_src_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_next;
            ptr_q      <= ptr_next;
            hs_valid_q <= hs_valid_next;
            hs_data_q  <= hs_data_next;
            hs_src_q   <= hs_src_next;
            done_q     <= done_next;
        end
    end

`ifdef HANDSHAKE_ARB_SENDER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_next;
    logic             timeout_q, timeout_next;

    // Counter holds busy cycles already elapsed; the flag is armed one count
    // early so it is visible on the TIMEOUT_CYCLES-th busy cycle.
    always_comb begin
        wd_cnt_next  = wd_cnt_q;
        timeout_next = timeout_q;
        if (state_next != IDLE) begin
            if (state_q == IDLE) begin
                wd_cnt_next = '0;
            end else if (wd_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                wd_cnt_next = wd_cnt_q + CNT_W'(1);
            end
            if (wd_cnt_next >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_next;
            timeout_q <= timeout_next;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign bus.o_timeout      = 1'b0;
`endif

    assign bus.o_grant    = i_rst ? '0 : grant_c;
    assign bus.o_busy     = !i_rst && (state_q != IDLE);
    assign bus.o_hs_valid = hs_valid_q;
    assign bus.o_hs_data  = hs_data_q;
    assign bus.o_hs_src   = hs_src_q;
    assign bus.o_done     = done_q;
endmodule

// File: tb/tb_handshake_arb_sender.sv
// Directed bench for handshake_arb_sender: single transfer, fairness, stale ack,
// watchdog (either build) and reset in the middle of a transfer.
module tb_handshake_arb_sender;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic ack_man;
    logic v_d1 = 1'b0;
    logic v_d2 = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   grant_cnt = 0;
    int   done_cnt  = 0;
    logic [31:0] dwords [NR];

    always #5 clk = ~clk;

    handshake_arb_sender_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    handshake_arb_sender #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.master)
    );

    // Ack peer: valid looped back through two flops, or driven directly.
    always @(posedge clk) begin
        v_d1 <= bus.o_hs_valid;
        v_d2 <= v_d1;
    end
    assign bus.i_hs_ack = loop_en ? v_d2 : ack_man;

    always @(negedge clk) begin
        if (|bus.o_grant) grant_cnt <= grant_cnt + 1;
        if (bus.o_done)   done_cnt  <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (bus.o_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_grant(input int budget, output logic [3:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            #1;
            if (|bus.o_grant) begin
                ok = 1'b1;
                g  = bus.o_grant;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        bit          ok;
        logic [3:0]  g;

        dwords[0] = 32'hA0A0_0001;
        dwords[1] = 32'hB1B1_0002;
        dwords[2] = 32'hCAFE_F00D;
        dwords[3] = 32'hD3D3_0004;
        rst       = 1'b1;
        loop_en   = 1'b1;
        ack_man   = 1'b0;
        bus.i_req  = '0;
        bus.i_data = {dwords[3], dwords[2], dwords[1], dwords[0]};

        // Reset: outputs cleared, grant and busy gated even with requests.
        step();
        bus.i_req = 4'hF;
        #1;
        check("rst_grant",    64'(bus.o_grant),    64'h0);
        check("rst_busy",     64'(bus.o_busy),     64'h0);
        check("rst_valid",    64'(bus.o_hs_valid), 64'h0);
        check("rst_done",     64'(bus.o_done),     64'h0);
        check("rst_data",     64'(bus.o_hs_data),  64'h0);
        check("rst_src",      64'(bus.o_hs_src),   64'h0);
        check("rst_timeout",  64'(bus.o_timeout),  64'h0);
        step();
        bus.i_req = '0;
        rst       = 1'b0;

        // Single transfer from requester 2.
        step();
        bus.i_req = 4'b0100;
        #1;
        check("single_grant", 64'(bus.o_grant), 64'h4);
        check("single_busy_at_grant", 64'(bus.o_busy), 64'h0);
        step();
        bus.i_req = '0;
        check("single_valid", 64'(bus.o_hs_valid), 64'h1);
        check("single_data",  64'(bus.o_hs_data),  64'hCAFEF00D);
        check("single_src",   64'(bus.o_hs_src),   64'h2);
        check("single_busy",  64'(bus.o_busy),     64'h1);
        wait_done(20, ok);
        check("single_done_seen", 64'(ok), 64'h1);
        check("single_busy_after", 64'(bus.o_busy), 64'h0);
        check("single_data_kept",  64'(bus.o_hs_data), 64'hCAFEF00D);
        check("single_grant_cnt",  64'(grant_cnt), 64'd1);
        step();
        check("single_done_pulse", 64'(bus.o_done), 64'h0);
        check("single_done_cnt",   64'(done_cnt),   64'd1);

        // Fairness: all requesting, order 0,1,2,3,0 from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_grant(40, g, ok);
            check("fair_grant_seen", 64'(ok), 64'h1);
            check("fair_grant", 64'(g), 64'(4'b0001 << (n % 4)));
            step();
            check("fair_src",  64'(bus.o_hs_src),  64'(n % 4));
            check("fair_data", 64'(bus.o_hs_data), 64'(dwords[n % 4]));
        end
        bus.i_req = '0;
        wait_done(40, ok);
        check("fair_drain_done", 64'(ok), 64'h1);

        // Stale ack after reset blocks grants until it drops.
        loop_en = 1'b0;
        ack_man = 1'b1;
        rst     = 1'b1;
        step();
        rst       = 1'b0;
        bus.i_req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stale_no_grant", 64'(bus.o_grant), 64'h0);
            check("stale_idle",     64'(bus.o_busy),  64'h0);
            step();
        end
        ack_man = 1'b0;
        #1;
        check("stale_grant_after_drop", 64'(bus.o_grant), 64'h1);
        step();
        bus.i_req = '0;

        // Watchdog: ack withheld, flag on the 8th SEND cycle when built in.
        for (int c = 1; c <= 10; c++) begin
            check("to_valid_held", 64'(bus.o_hs_valid), 64'h1);
`ifdef HANDSHAKE_ARB_SENDER_TIMEOUT_EN
            check("to_flag", 64'(bus.o_timeout), 64'(c >= 8));
`else
            check("to_flag_off", 64'(bus.o_timeout), 64'h0);
`endif
            step();
        end
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        wait_done(10, ok);
        check("to_done_seen", 64'(ok), 64'h1);
`ifdef HANDSHAKE_ARB_SENDER_TIMEOUT_EN
        check("to_sticky", 64'(bus.o_timeout), 64'h1);
`else
        check("to_sticky_off", 64'(bus.o_timeout), 64'h0);
`endif

        // Reset in the middle of SEND abandons the transfer.
        bus.i_req = 4'b0010;
        #1;
        check("mid_grant", 64'(bus.o_grant), 64'h2);
        step();
        bus.i_req = '0;
        check("mid_valid", 64'(bus.o_hs_valid), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_busy_in_rst", 64'(bus.o_busy), 64'h0);
        step();
        rst = 1'b0;
        check("mid_valid_after",   64'(bus.o_hs_valid), 64'h0);
        check("mid_busy_after",    64'(bus.o_busy),     64'h0);
        check("mid_done_after",    64'(bus.o_done),     64'h0);
        check("mid_timeout_after", 64'(bus.o_timeout),  64'h0);
        check("mid_src_after",     64'(bus.o_hs_src),   64'h0);
        step();
        step();
        check("mid_no_done", 64'(done_cnt), 64'd7);

        // Pointer back at 0: requester 0 wins among all.
        bus.i_req = 4'hF;
        #1;
        check("mid_ptr_zero", 64'(bus.o_grant), 64'h1);
        step();
        bus.i_req = '0;
        check("final_src",  64'(bus.o_hs_src),  64'h0);
        check("final_data", 64'(bus.o_hs_data), 64'(dwords[0]));
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        wait_done(10, ok);
        check("final_done_seen", 64'(ok), 64'h1);
        step();
        check("final_done_cnt", 64'(done_cnt), 64'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
